// File: rtl/uart_tx_fifo.sv
// UART transmitter with a 2**FIFO_AW-entry byte FIFO in front of an 8N1 serializer.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic               SI_ClkIn,
  input  logic               SI_Reset_N,
  input  logic [7:0]         tx_data,
  input  logic               tx_wr,
  output logic               tx_full,
  output logic               tx_empty,
  output logic               tx_busy,
  output logic               tx_ovf,
  output logic [FIFO_AW:0]   tx_count,
  output logic               UART_TX
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned TW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CW    = FIFO_AW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  state_e               state_q;
  logic [TW-1:0]        timer_q;
  logic [2:0]           idx_q;
  logic [7:0]           shreg_q;
`ifdef UART_TX_PARITY_EN
  logic                 par_q;
`endif
  logic [FIFO_AW-1:0]   wr_ptr_q;
  logic [FIFO_AW-1:0]   rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        count_d;
  logic                 full_q;
  logic                 empty_q;
  logic                 busy_q;
  logic                 ovf_q;
  logic                 line_q;
  logic [7:0]           mem_q [DEPTH];

  logic                 bit_done_c;
  logic                 wr_acc_c;
  logic                 pop_c;
  logic                 line_c;
  logic [7:0]           head_c;

  assign bit_done_c = (timer_q == TW'(CLKS_PER_BIT - 1));
  assign wr_acc_c   = tx_wr && !full_q;
  // Pop when idle, or at the last cycle of STOP so the next frame follows back to back.
  assign pop_c      = !empty_q && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_done_c));
  assign head_c     = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (wr_acc_c && !pop_c) count_d = count_q + CW'(1);
    else if (!wr_acc_c && pop_c) count_d = count_q - CW'(1);
  end

  // Line level for the current state; registered one cycle later into UART_TX.
  always_comb begin
    line_c = 1'b1;
    case (state_q)
      S_START:  line_c = 1'b0;
      S_DATA:   line_c = shreg_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: line_c = par_q;
`endif
      default:  line_c = 1'b1;
    endcase
  end

  always_ff @(posedge SI_ClkIn) begin
    if (wr_acc_c) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge SI_ClkIn) begin
    if (!SI_Reset_N) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      line_q   <= 1'b1;
    end else begin
      if (wr_acc_c) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop_c)    rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      if (tx_wr && full_q) ovf_q <= 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
      line_q  <= line_c;
      busy_q  <= pop_c || ((state_q != S_IDLE) && !((state_q == S_STOP) && bit_done_c));

      if (state_q != S_IDLE) timer_q <= bit_done_c ? '0 : timer_q + TW'(1);

      if (pop_c) begin
        shreg_q <= head_c;
`ifdef UART_TX_PARITY_EN
        par_q   <= ^head_c;
`endif
      end

      case (state_q)
        S_IDLE: begin
          timer_q <= '0;
          if (pop_c) state_q <= S_START;
        end
        S_START: begin
          if (bit_done_c) begin
            state_q <= S_DATA;
            idx_q   <= '0;
          end
        end
        S_DATA: begin
          if (bit_done_c) begin
            shreg_q <= {1'b0, shreg_q[7:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_done_c) state_q <= S_STOP;
        end
`endif
        S_STOP: begin
          if (bit_done_c) state_q <= pop_c ? S_START : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_full  = full_q;
  assign tx_empty = empty_q;
  assign tx_busy  = busy_q;
  assign tx_ovf   = ovf_q;
  assign tx_count = count_q;
  assign UART_TX  = line_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic against a frame-level model.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic          clk;
  logic          rst_n;
  logic [7:0]    tx_data;
  logic          tx_wr;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_busy;
  logic          tx_ovf;
  logic [AW:0]   tx_count;
  logic          uart_line;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: byte queue, byte on the wire, cycles left in its frame, sticky overflow.
  logic [7:0] m_q[$];
  logic [7:0] m_cur  = 8'h00;
  int         m_left = 0;
  logic       m_ovf  = 1'b0;
  logic       line_nx = 1'b1;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .SI_ClkIn   (clk),
    .SI_Reset_N (rst_n),
    .tx_data    (tx_data),
    .tx_wr      (tx_wr),
    .tx_full    (tx_full),
    .tx_empty   (tx_empty),
    .tx_busy    (tx_busy),
    .tx_ovf     (tx_ovf),
    .tx_count   (tx_count),
    .UART_TX    (uart_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Level of the wire for a frame of byte c with `left` cycles still to go.
  function automatic logic line_of(input logic [7:0] c, input int left);
    int b;
    if (left == 0) return 1'b1;
    b = (FRAME - left) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return c[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^c;
`endif
    return 1'b1;
  endfunction

  task automatic step(input logic wr, input logic [7:0] d, input logic rst);
    logic exp_line;
    logic pop;
    int   sz;
    tx_wr   = wr;
    tx_data = d;
    rst_n   = ~rst;
    @(posedge clk);
    // The wire shows the level decided one cycle earlier; reset forces it high at once.
    exp_line = rst ? 1'b1 : line_nx;
    if (rst) begin
      m_q.delete();
      m_left = 0;
      m_ovf  = 1'b0;
    end else begin
      sz  = m_q.size();
      pop = (sz > 0) && (m_left <= 1);
      if (wr && sz == DEPTH) m_ovf = 1'b1;
      if (wr && sz < DEPTH) m_q.push_back(d);
      if (pop) begin
        m_cur  = m_q.pop_front();
        m_left = FRAME;
      end else if (m_left > 0) begin
        m_left--;
      end
    end
    line_nx = rst ? 1'b1 : line_of(m_cur, m_left);
    #1;
    check("tx_count", 32'(tx_count), 32'(m_q.size()));
    check("tx_full",  32'(tx_full),  32'(m_q.size() == DEPTH));
    check("tx_empty", 32'(tx_empty), 32'(m_q.size() == 0));
    check("tx_busy",  32'(tx_busy),  32'(m_left > 0));
    check("tx_ovf",   32'(tx_ovf),   32'(m_ovf));
    check("UART_TX",  32'(uart_line), 32'(exp_line));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    tx_wr   = 1'b0;
    tx_data = 8'h00;

    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

    // Single byte, alternating bits.
    step(1'b1, 8'h55, 1'b0);
    idle(FRAME + 8);

    // Five back-to-back writes fill the FIFO behind the first pop; the sixth overflows.
    for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 1'b0);
    idle(6 * FRAME);

    // Keep hammering writes across a frame boundary so one lands on the pop edge while full.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h07 + 8'(i), 1'b0);
    for (int i = 0; i < FRAME + 4; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
    idle(6 * FRAME);

    // Reset in the middle of the data bits of 0xA5 with two bytes queued.
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b1, 8'h96, 1'b0);
    idle(3 * CPB + 2);
    step(1'b0, 8'h00, 1'b1);
    idle(3 * FRAME);

    // Ten single-byte transfers walk the pointers around more than once.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      idle(FRAME + 3);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 6) == 0), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 699) == 0));
    end
    idle(6 * FRAME);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
